// File: rtl/dmem_burst_reader.sv
// dmem_burst_reader: burst read controller for the 256x8 data memory with a credit-limited return FIFO.
// Optional feature: define DMEM_RD_BYPASS_EN for write-first forwarding when a snooped write hits the address being read.
module dmem_burst_reader #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_req_valid_i,
    output logic              rd_req_ready_o,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic [LEN_W-1:0]  rd_len_i,
    output logic              mem_rd_en_o,
    output logic [ADDR_W-1:0] mem_rd_addr_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_write_i,
    input  logic [ADDR_W-1:0] a_i,
    input  logic [DATA_W-1:0] wd_i,
    output logic              rd_data_valid_o,
    input  logic              rd_data_ready_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_last_o,
    output logic              busy_o
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW+1:0] DEPTH = (PW+2)'(FIFO_DEPTH);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LEN_W:0]      rem_q, rem_d;
    logic                out_q, tag_q;
    logic [PW:0]         wptr_q, rptr_q, count;
    logic [PW+1:0]       occ;
    logic [DATA_W-1:0]   fifo_data_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_last_q;
    logic [DATA_W-1:0]   cap_data;
    logic                issue, last_issue, push, pop;
    assign count      = wptr_q - rptr_q;
    assign occ        = {1'b0, count} + {{(PW+1){1'b0}}, out_q};
    assign issue      = (state_q == ISSUE) && (occ < DEPTH);
    assign last_issue = issue && (rem_q == (LEN_W+1)'(1));
    assign push       = out_q;
    assign pop        = rd_data_valid_o && rd_data_ready_i;
    assign rd_req_ready_o  = (state_q == IDLE);
    assign busy_o          = (state_q != IDLE);
    assign mem_rd_en_o     = issue;
    assign mem_rd_addr_o   = addr_q;
    assign rd_data_valid_o = (count != '0);
    assign rd_data_o       = rd_data_valid_o ? fifo_data_q[rptr_q[PW-1:0]] : '0;
    assign rd_last_o       = rd_data_valid_o && fifo_last_q[rptr_q[PW-1:0]];
`ifdef DMEM_RD_BYPASS_EN
    logic              byp_q;
    logic [DATA_W-1:0] byp_data_q;
    // remember a write that lands on the address being read this cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byp_q      <= 1'b0;
            byp_data_q <= '0;
        end else begin
            byp_q <= issue && mem_write_i && (a_i == addr_q);
            if (issue && mem_write_i && (a_i == addr_q)) byp_data_q <= wd_i;
        end
    end
    assign cap_data = byp_q ? byp_data_q : mem_rdata_i;
`else
    logic unused_snoop;
    assign unused_snoop = ^{mem_write_i, a_i, wd_i};
    assign cap_data     = mem_rdata_i;
`endif
    // next-state: accept in IDLE, step address/count per issue, leave DRAIN once nothing is queued or in flight
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        if (state_q == IDLE && rd_req_valid_i) begin
            state_d = ISSUE;
            addr_d  = rd_addr_i;
            rem_d   = {1'b0, rd_len_i} + 1'b1;
        end
        if (issue) begin
            addr_d = addr_q + 1'b1;
            rem_d  = rem_q - 1'b1;
            state_d = last_issue ? DRAIN : state_q;
        end
        if (state_q == DRAIN && count == '0 && !out_q) state_d = IDLE;
    end
    // control registers; the in-flight flag and its last tag follow each issue by one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            out_q   <= 1'b0;
            tag_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            out_q   <= issue;
            tag_q   <= last_issue;
        end
    end
    // FIFO pointers; push and pop may coincide at any occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
        end
    end
    // FIFO storage captures the returned byte and its last tag
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_q[wptr_q[PW-1:0]] <= cap_data;
            fifo_last_q[wptr_q[PW-1:0]] <= tag_q;
        end
    end
endmodule

// File: tb/tb_dmem_burst_reader.sv
// tb_dmem_burst_reader: directed table-driven bench for dmem_burst_reader with a behavioural 256x8 memory.
module tb_dmem_burst_reader;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rd_req_valid = 1'b0, rd_req_ready;
    logic [7:0] rd_addr = '0;
    logic [3:0] rd_len = '0;
    logic       mem_rd_en;
    logic [7:0] mem_rd_addr, mem_rdata;
    logic       mem_write = 1'b0;
    logic [7:0] a = '0, wd = '0;
    logic       rd_data_valid, rd_data_ready = 1'b0;
    logic [7:0] rd_data;
    logic       rd_last, busy;
    logic [7:0] mem [256];
    int         n_vec = 0, n_err = 0;

    always #5 clk = ~clk;

    dmem_burst_reader dut (
        .clk(clk), .rst_n(rst_n),
        .rd_req_valid_i(rd_req_valid), .rd_req_ready_o(rd_req_ready),
        .rd_addr_i(rd_addr), .rd_len_i(rd_len),
        .mem_rd_en_o(mem_rd_en), .mem_rd_addr_o(mem_rd_addr), .mem_rdata_i(mem_rdata),
        .mem_write_i(mem_write), .a_i(a), .wd_i(wd),
        .rd_data_valid_o(rd_data_valid), .rd_data_ready_i(rd_data_ready),
        .rd_data_o(rd_data), .rd_last_o(rd_last), .busy_o(busy)
    );

    // synchronous-read memory, read-first on a same-address write
    always @(posedge clk) begin
        if (mem_write) mem[a] <= wd;
        if (mem_rd_en) mem_rdata <= mem[mem_rd_addr];
    end

    function automatic logic [7:0] exp_byte(input logic [7:0] ad);
        return (ad == 8'h10) ? 8'hA5 : (ad == 8'h30) ? 8'h11 : ~ad;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] addr;
        logic [3:0] len;
        int         stall;
        logic [7:0] first;
        logic [7:0] last;
    } vec_t;
    vec_t vecs [5];

    task automatic wait_idle();
        rd_data_ready = 1'b1;
        for (int i = 0; i < 4 && !rd_req_ready; i++) @(negedge clk);
        chk("idle_ready", rd_req_ready, 1);
        chk("idle_busy", busy, 0);
        chk("idle_valid", rd_data_valid, 0);
    endtask

    task automatic run_burst(input vec_t v);
        int cyc, issued, got, fen, fval;
        logic [7:0] pd;
        logic pl, pstall;
        @(negedge clk);
        chk("req_ready", rd_req_ready, 1);
        rd_req_valid = 1'b1; rd_addr = v.addr; rd_len = v.len;
        @(negedge clk);
        rd_req_valid = 1'b0;
        cyc = 1; issued = 0; got = 0; fen = -1; fval = -1; pstall = 1'b0; pd = '0; pl = 1'b0;
        while (got <= int'(v.len) && cyc < 200) begin
            rd_data_ready = (cyc > v.stall);
            chk("busy", busy, 1);
            if (mem_rd_en) begin
                chk("issue_addr", mem_rd_addr, 8'(v.addr + issued));
                if (fen < 0) fen = cyc;
                issued++;
            end
            if (v.stall >= 6 && cyc == v.stall) begin
                chk("stall_issues", issued, 4);
                chk("stall_no_issue", mem_rd_en, 0);
            end
            if (rd_data_valid && fval < 0) fval = cyc;
            if (pstall) begin
                chk("hold_valid", rd_data_valid, 1);
                chk("hold_data", rd_data, pd);
                chk("hold_last", rd_last, pl);
            end
            if (rd_data_valid && rd_data_ready) begin
                if (got == 0) chk("first_data", rd_data, v.first);
                if (got == int'(v.len)) chk("last_data", rd_data, v.last);
                chk("beat_data", rd_data, exp_byte(8'(v.addr + got)));
                chk("beat_last", rd_last, got == int'(v.len));
                got++;
            end
            pstall = rd_data_valid && !rd_data_ready;
            pd = rd_data; pl = rd_last;
            @(negedge clk);
            cyc++;
        end
        chk("beats", got, v.len + 1);
        chk("issued", issued, v.len + 1);
        if (v.stall == 0) begin
            chk("latency", fval - fen, 2);
            chk("throughput", cyc - 1 - fval, v.len);
        end
        wait_idle();
    endtask

    initial begin
        vecs[0] = '{addr: 8'h10, len: 4'd0, stall: 0,  first: 8'hA5, last: 8'hA5};
        vecs[1] = '{addr: 8'h20, len: 4'd3, stall: 0,  first: 8'hDF, last: 8'hDC};
        vecs[2] = '{addr: 8'hFE, len: 4'd2, stall: 0,  first: 8'h01, last: 8'hFF};
        vecs[3] = '{addr: 8'h40, len: 4'd7, stall: 10, first: 8'hBF, last: 8'hB8};
        vecs[4] = '{addr: 8'h80, len: 4'd15, stall: 3, first: 8'h7F, last: 8'h70};
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            mem_write = 1'b1; a = 8'(i); wd = exp_byte(8'(i));
        end
        @(negedge clk);
        mem_write = 1'b0;
        chk("rst_req_ready", rd_req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_rd_en", mem_rd_en, 0);
        chk("rst_valid", rd_data_valid, 0);
        chk("rst_last", rd_last, 0);
        chk("rst_data", rd_data, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) run_burst(vecs[i]);
        // collision: write lands on the address being read in the issue cycle
        rd_data_ready = 1'b1;
        @(negedge clk);
        rd_req_valid = 1'b1; rd_addr = 8'h30; rd_len = 4'd0;
        @(negedge clk);
        rd_req_valid = 1'b0;
        chk("col_rd_en", mem_rd_en, 1);
        chk("col_addr", mem_rd_addr, 8'h30);
        mem_write = 1'b1; a = 8'h30; wd = 8'h22;
        @(negedge clk);
        mem_write = 1'b0;
        @(negedge clk);
        chk("col_valid", rd_data_valid, 1);
`ifdef DMEM_RD_BYPASS_EN
        chk("col_data", rd_data, 8'h22);
`else
        chk("col_data", rd_data, 8'h11);
`endif
        chk("col_last", rd_last, 1);
        @(negedge clk);
        wait_idle();
        // reset in the middle of a long burst
        begin
            int got = 0;
            @(negedge clk);
            rd_req_valid = 1'b1; rd_addr = 8'h50; rd_len = 4'd15;
            @(negedge clk);
            rd_req_valid = 1'b0;
            for (int c = 0; c < 50 && got < 3; c++) begin
                if (rd_data_valid) got++;
                @(negedge clk);
            end
            chk("mid_beats", got, 3);
            rst_n = 1'b0;
            #1;
            chk("mid_rst_valid", rd_data_valid, 0);
            chk("mid_rst_rd_en", mem_rd_en, 0);
            chk("mid_rst_busy", busy, 0);
            chk("mid_rst_ready", rd_req_ready, 1);
            chk("mid_rst_data", rd_data, 0);
            chk("mid_rst_last", rd_last, 0);
            @(negedge clk);
            rst_n = 1'b1;
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                chk("post_rst_valid", rd_data_valid, 0);
                chk("post_rst_rd_en", mem_rd_en, 0);
                chk("post_rst_ready", rd_req_ready, 1);
            end
        end
        run_burst(vecs[1]);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
